// File: rtl/tile_fetch.sv
// Tile fetch: VGA counters -> tile/sprite select code and in-tile ROM address, using an on-chip game map RAM.
// Optional power-up map clear is built when TILE_FETCH_MAP_CLEAR_EN is defined.
module tile_fetch #(
    parameter int TILE_LOG2 = 6,
    parameter int MAP_W     = 16,
    parameter int MAP_H     = 12,
    parameter int SYNC_DLY  = 4
) (
    input  logic                   i_pclk,
    input  logic                   i_rst_n,
    input  logic [10:0]            i_hcount,
    input  logic [10:0]            i_vcount,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_hblnk,
    input  logic                   i_vblnk,
    input  logic                   i_map_we,
    input  logic [7:0]             i_map_waddr,
    input  logic [3:0]             i_map_wdata,
    input  logic [10:0]            i_plr1_x,
    input  logic [10:0]            i_plr1_y,
    input  logic [10:0]            i_plr2_x,
    input  logic [10:0]            i_plr2_y,
    output logic [3:0]             o_sel,
    output logic [2*TILE_LOG2-1:0] o_rom_addr,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_hblnk,
    output logic                   o_vblnk,
    output logic                   o_map_busy
);

    localparam int MAP_N = MAP_W * MAP_H;
    localparam int AW    = $clog2(MAP_N);
    localparam int TW    = 2 * TILE_LOG2;
    localparam logic [3:0] SEL_PLR1 = 4'd5;
    localparam logic [3:0] SEL_PLR2 = 4'd6;
    localparam logic [3:0] SEL_NONE = 4'hF;

    logic [3:0] r_map [MAP_N];
    logic [3:0] r_rdata;

    logic [10:0]   w_col, w_row, w_dx1, w_dy1, w_dx2, w_dy2;
    logic          w_blank, w_in_map, w_p1_hit, w_p2_hit;
    logic [AW-1:0] w_raddr;

    assign w_col    = i_hcount >> TILE_LOG2;
    assign w_row    = i_vcount >> TILE_LOG2;
    assign w_blank  = i_hblnk | i_vblnk;
    assign w_in_map = !w_blank && (w_col < 11'(MAP_W)) && (w_row < 11'(MAP_H));
    assign w_raddr  = w_in_map ? (AW'(w_row) * AW'(MAP_W) + AW'(w_col)) : '0;

    // Unsigned wrap makes pixels left of / above the sprite look huge, so they miss.
    assign w_dx1    = i_hcount - i_plr1_x;
    assign w_dy1    = i_vcount - i_plr1_y;
    assign w_dx2    = i_hcount - i_plr2_x;
    assign w_dy2    = i_vcount - i_plr2_y;
    assign w_p1_hit = (w_dx1[10:TILE_LOG2] == '0) && (w_dy1[10:TILE_LOG2] == '0);
    assign w_p2_hit = (w_dx2[10:TILE_LOG2] == '0) && (w_dy2[10:TILE_LOG2] == '0);

    logic          w_busy, w_we, w_wr_ok;
    logic [AW-1:0] w_waddr;
    logic [3:0]    w_wdata;

    assign w_wr_ok = i_map_we && (16'(i_map_waddr) < 16'(MAP_N));

`ifdef TILE_FETCH_MAP_CLEAR_EN
    // state   | meaning
    // S_CLEAR | writing PATH to every map address, o_map_busy high
    // S_IDLE  | normal operation, game logic owns the write port
    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_clr_addr, w_clr_addr_nxt;

    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            S_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + AW'(1);
                if (r_clr_addr == AW'(MAP_N - 1)) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_addr_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy  = (r_state == S_CLEAR);
    assign w_we    = w_busy || w_wr_ok;
    assign w_waddr = w_busy ? r_clr_addr : AW'(i_map_waddr);
    assign w_wdata = w_busy ? 4'd0 : i_map_wdata;
`else
    assign w_busy  = 1'b0;
    assign w_we    = w_wr_ok;
    assign w_waddr = AW'(i_map_waddr);
    assign w_wdata = i_map_wdata;
`endif

    // Read-first RAM; reset gates writes so the map survives a reset.
    always_ff @(posedge i_pclk) begin
        if (i_rst_n && w_we)
            r_map[w_waddr] <= w_wdata;
        r_rdata <= r_map[w_raddr];
    end

    logic          r_in_map, r_blank, r_p1_hit, r_p2_hit;
    logic [TW-1:0] r_tile_off, r_p1_off, r_p2_off;

    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            r_in_map   <= 1'b0;
            r_blank    <= 1'b0;
            r_p1_hit   <= 1'b0;
            r_p2_hit   <= 1'b0;
            r_tile_off <= '0;
            r_p1_off   <= '0;
            r_p2_off   <= '0;
        end else begin
            r_in_map   <= w_in_map;
            r_blank    <= w_blank;
            r_p1_hit   <= w_p1_hit;
            r_p2_hit   <= w_p2_hit;
            r_tile_off <= {i_vcount[TILE_LOG2-1:0], i_hcount[TILE_LOG2-1:0]};
            r_p1_off   <= {w_dy1[TILE_LOG2-1:0], w_dx1[TILE_LOG2-1:0]};
            r_p2_off   <= {w_dy2[TILE_LOG2-1:0], w_dx2[TILE_LOG2-1:0]};
        end
    end

    logic [3:0]    r_sel;
    logic [TW-1:0] r_rom_addr;

    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            r_sel      <= '0;
            r_rom_addr <= '0;
        end else if (w_busy) begin
            r_sel      <= SEL_NONE;
            r_rom_addr <= '0;
        end else if (r_p1_hit && !r_blank) begin
            r_sel      <= SEL_PLR1;
            r_rom_addr <= r_p1_off;
        end else if (r_p2_hit && !r_blank) begin
            r_sel      <= SEL_PLR2;
            r_rom_addr <= r_p2_off;
        end else if (r_in_map) begin
            r_sel      <= r_rdata;
            r_rom_addr <= r_tile_off;
        end else begin
            r_sel      <= SEL_NONE;
            r_rom_addr <= '0;
        end
    end

    logic [SYNC_DLY-1:0][3:0] r_tpipe;

    always_ff @(posedge i_pclk) begin
        if (!i_rst_n)
            r_tpipe <= '0;
        else
            r_tpipe <= {r_tpipe[SYNC_DLY-2:0], {i_hsync, i_vsync, i_hblnk, i_vblnk}};
    end

    assign {o_hsync, o_vsync, o_hblnk, o_vblnk} = r_tpipe[SYNC_DLY-1];
    assign o_sel      = r_sel;
    assign o_rom_addr = r_rom_addr;
    assign o_map_busy = w_busy;

endmodule

// File: tb/tb_tile_fetch.sv
// Self-checking bench for tile_fetch: scoreboard queues hold expected pixel and timing outputs.
module tb_tile_fetch;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic        we;
    logic [7:0]  waddr;
    logic [3:0]  wdata;
    logic [10:0] p1x, p1y, p2x, p2y;
    logic [3:0]  sel;
    logic [11:0] rom;
    logic        ohs, ovs, ohb, ovb, busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_q[$];
    logic [3:0]  tq[$];
    logic [3:0]  shadow[192];

`ifdef TILE_FETCH_MAP_CLEAR_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    tile_fetch dut (
        .i_pclk(pclk), .i_rst_n(rst_n),
        .i_hcount(hc), .i_vcount(vc),
        .i_hsync(hs), .i_vsync(vs), .i_hblnk(hb), .i_vblnk(vb),
        .i_map_we(we), .i_map_waddr(waddr), .i_map_wdata(wdata),
        .i_plr1_x(p1x), .i_plr1_y(p1y), .i_plr2_x(p2x), .i_plr2_y(p2y),
        .o_sel(sel), .o_rom_addr(rom),
        .o_hsync(ohs), .o_vsync(ovs), .o_hblnk(ohb), .o_vblnk(ovb),
        .o_map_busy(busy)
    );

    always #5 pclk = ~pclk;

    function automatic logic [15:0] model_px(input logic [10:0] h, input logic [10:0] v,
                                             input logic hbl, input logic vbl);
        logic [10:0] dx1, dy1, dx2, dy2;
        int col, row;
        dx1 = h - p1x; dy1 = v - p1y;
        dx2 = h - p2x; dy2 = v - p2y;
        col = int'(h) / 64;
        row = int'(v) / 64;
        if (!(hbl || vbl) && dx1 < 11'd64 && dy1 < 11'd64) return {4'd5, dy1[5:0], dx1[5:0]};
        if (!(hbl || vbl) && dx2 < 11'd64 && dy2 < 11'd64) return {4'd6, dy2[5:0], dx2[5:0]};
        if (!(hbl || vbl) && col < 16 && row < 12) return {shadow[row*16+col], v[5:0], h[5:0]};
        return {4'hF, 12'd0};
    endfunction

    task automatic send_px(input logic [10:0] h, input logic [10:0] v,
                           input logic hbl, input logic vbl, input logic [15:0] exp);
        hc = h; vc = v; hb = hbl; vb = vbl;
        sb_q.push_back(exp);
    endtask

    task automatic players_far();
        p1x = 11'd1000; p1y = 11'd700; p2x = 11'd1000; p2y = 11'd700;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        hc = '0; vc = '0; hs = 1'b0; vs = 1'b0; hb = 1'b0; vb = 1'b0;
        players_far();
        for (int i = 0; i < 192; i++) shadow[i] = 4'd0;
        repeat (2) @(negedge pclk);
        checks++;
        if ({sel, rom} !== 16'd0) begin
            errors++; $display("FAIL reset_pix: got sel=%h addr=%h, want 0 0", sel, rom);
        end
        checks++;
        if ({ohs, ovs, ohb, ovb, busy} !== {4'b0000, EXP_BUSY_RST}) begin
            errors++; $display("FAIL reset_sync_busy: got %b, want %b", {ohs, ovs, ohb, ovb, busy}, {4'b0000, EXP_BUSY_RST});
        end
        rst_n = 1'b1;
`ifdef TILE_FETCH_MAP_CLEAR_EN
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            we = (cnt == 10); waddr = 8'd5; wdata = 4'd7;
            if (cnt == 20) begin
                checks++;
                if (sel !== 4'hF) begin
                    errors++; $display("FAIL busy_sel: got %h, want f", sel);
                end
            end
            @(negedge pclk);
        end
        we = 1'b0;
        checks++;
        if (cnt != 192) begin
            errors++; $display("FAIL busy_len: got %0d cycles, want 192", cnt);
        end
`else
        cnt = 0;
        @(negedge pclk);
`endif
    endtask

`ifdef TILE_FETCH_MAP_CLEAR_EN
    task automatic test_clear_restart();
        int cnt;
        rst_n = 1'b0; @(negedge pclk);
        rst_n = 1'b1; repeat (50) @(negedge pclk);
        rst_n = 1'b0; @(negedge pclk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL restart_busy: got %b, want 1", busy);
        end
        rst_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge pclk);
        end
        checks++;
        if (cnt != 192) begin
            errors++; $display("FAIL restart_len: got %0d cycles, want 192", cnt);
        end
    endtask
`endif

    task automatic test_map_fill();
        for (int a = 0; a < 192; a++) begin
            @(negedge pclk);
            we = 1'b1; waddr = 8'(a); wdata = 4'((a * 7) % 9);
            shadow[a] = 4'((a * 7) % 9);
        end
        @(negedge pclk);
        we = 1'b0;
    endtask

    task automatic test_map_scan();
        logic [15:0] e;
        logic [10:0] h, v;
        players_far();
        for (int i = 0; i < 194; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                e = sb_q.pop_front();
                checks++;
                if ({sel, rom} !== e) begin
                    errors++; $display("FAIL map_scan: got sel=%h addr=%h, want sel=%h addr=%h", sel, rom, e[15:12], e[11:0]);
                end
            end
            if (i < 192) begin
                h = 11'((i % 16) * 64 + (i / 16) * 3);
                v = 11'((i / 16) * 64 + (i % 16) * 2);
                send_px(h, v, 1'b0, 1'b0, model_px(h, v, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_tile_lookup();
        logic [15:0] e;
        players_far();
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                e = sb_q.pop_front();
                checks++;
                if ({sel, rom} !== e) begin
                    errors++; $display("FAIL tile_lookup: got sel=%h addr=%h, want sel=%h addr=%h", sel, rom, e[15:12], e[11:0]);
                end
            end
            if (i == 0) send_px(11'd70, 11'd65, 1'b0, 1'b0, {4'd2, 6'd1, 6'd6});
        end
    endtask

    task automatic test_out_of_map();
        logic [15:0] e;
        players_far();
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                e = sb_q.pop_front();
                checks++;
                if ({sel, rom} !== e) begin
                    errors++; $display("FAIL out_of_map: got sel=%h addr=%h, want sel=%h addr=%h", sel, rom, e[15:12], e[11:0]);
                end
            end
            case (i)
                0: send_px(11'd1030, 11'd100, 1'b0, 1'b0, {4'hF, 12'd0});
                1: send_px(11'd10, 11'd65, 1'b1, 1'b0, {4'hF, 12'd0});
                2: send_px(11'd10, 11'd65, 1'b0, 1'b1, {4'hF, 12'd0});
                default: ;
            endcase
        end
    endtask

    task automatic test_players();
        logic [15:0] e;
        p1x = 11'd100; p1y = 11'd100; p2x = 11'd120; p2y = 11'd100;
        for (int i = 0; i < 9; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                e = sb_q.pop_front();
                checks++;
                if ({sel, rom} !== e) begin
                    errors++; $display("FAIL players: got sel=%h addr=%h, want sel=%h addr=%h", sel, rom, e[15:12], e[11:0]);
                end
            end
            case (i)
                0: send_px(11'd130, 11'd110, 1'b0, 1'b0, {4'd5, 6'd10, 6'd30});
                1: send_px(11'd99,  11'd110, 1'b0, 1'b0, {4'd2, 6'd46, 6'd35});
                2: send_px(11'd175, 11'd110, 1'b0, 1'b0, {4'd6, 6'd10, 6'd55});
                3: send_px(11'd130, 11'd110, 1'b0, 1'b1, {4'hF, 12'd0});
                4: send_px(11'd163, 11'd163, 1'b0, 1'b0, {4'd5, 6'd63, 6'd63});
                5: send_px(11'd164, 11'd110, 1'b0, 1'b0, {4'd6, 6'd10, 6'd44});
                6: send_px(11'd100, 11'd100, 1'b0, 1'b0, {4'd5, 6'd0, 6'd0});
                default: ;
            endcase
        end
    endtask

    task automatic test_read_first();
        logic [15:0] e;
        players_far();
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                e = sb_q.pop_front();
                checks++;
                if ({sel, rom} !== e) begin
                    errors++; $display("FAIL read_first: got sel=%h addr=%h, want sel=%h addr=%h", sel, rom, e[15:12], e[11:0]);
                end
            end
            case (i)
                0: begin
                    we = 1'b1; waddr = 8'd0; wdata = 4'd3;
                    send_px(11'd0, 11'd0, 1'b0, 1'b0, {4'd0, 12'd0});
                    shadow[0] = 4'd3;
                end
                1: begin
                    we = 1'b0;
                    send_px(11'd0, 11'd0, 1'b0, 1'b0, {4'd3, 12'd0});
                end
                2: begin
                    we = 1'b1; waddr = 8'd200; wdata = 4'd5;
                    send_px(11'd512, 11'd0, 1'b0, 1'b0, model_px(11'd512, 11'd0, 1'b0, 1'b0));
                end
                3: begin
                    we = 1'b0;
                    send_px(11'd512, 11'd0, 1'b0, 1'b0, model_px(11'd512, 11'd0, 1'b0, 1'b0));
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_sync_delay();
        logic [3:0] e, t;
        tq.delete();
        for (int i = 0; i < 44; i++) begin
            @(negedge pclk);
            if (i >= 4) begin
                e = tq.pop_front();
                checks++;
                if ({ohs, ovs, ohb, ovb} !== e) begin
                    errors++; $display("FAIL sync_delay: got %b, want %b", {ohs, ovs, ohb, ovb}, e);
                end
            end
            if (i < 40) begin
                if (i < 8) t = (i >= 4) ? 4'b1000 : 4'b0000;
                else t = 4'($urandom_range(0, 15));
                {hs, vs, hb, vb} = t;
                tq.push_back(t);
            end
        end
        {hs, vs, hb, vb} = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        logic [10:0] h, v;
        logic hbl, vbl;
        p1x = 11'd100; p1y = 11'd100; p2x = 11'd120; p2y = 11'd100;
        for (int i = 0; i < 82; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                e = sb_q.pop_front();
                checks++;
                if ({sel, rom} !== e) begin
                    errors++; $display("FAIL back_to_back: got sel=%h addr=%h, want sel=%h addr=%h", sel, rom, e[15:12], e[11:0]);
                end
            end
            if (i < 80) begin
                if ($urandom_range(0, 1) == 0) begin
                    h = 11'($urandom_range(60, 220)); v = 11'($urandom_range(60, 200));
                end else begin
                    h = 11'($urandom_range(0, 1100)); v = 11'($urandom_range(0, 800));
                end
                hbl = ($urandom_range(0, 7) == 0);
                vbl = ($urandom_range(0, 7) == 0);
                send_px(h, v, hbl, vbl, model_px(h, v, hbl, vbl));
            end
        end
    endtask

    task automatic test_reset_mid_line();
        int cnt;
        logic [3:0] exp_after;
        players_far();
        hc = 11'd70; vc = 11'd65; hb = 1'b0; vb = 1'b0; hs = 1'b1; vs = 1'b1;
        repeat (5) @(negedge pclk);
        checks++;
        if ({sel, ohs, ovs} !== {4'd2, 2'b11}) begin
            errors++; $display("FAIL pre_reset: got sel=%h sync=%b%b, want sel=2 sync=11", sel, ohs, ovs);
        end
        rst_n = 1'b0;
        @(negedge pclk);
        checks++;
        if ({sel, rom, ohs, ovs, ohb, ovb, busy} !== {16'd0, 4'b0000, EXP_BUSY_RST}) begin
            errors++; $display("FAIL mid_reset: got sel=%h addr=%h sync=%b busy=%b, want all 0 busy=%b", sel, rom, {ohs, ovs, ohb, ovb}, busy, EXP_BUSY_RST);
        end
        rst_n = 1'b1;
        @(negedge pclk);
        checks++;
        if ({sel, ohs, ovs} !== {4'hF, 2'b00}) begin
            errors++; $display("FAIL post_reset_flush: got sel=%h sync=%b%b, want sel=f sync=00", sel, ohs, ovs);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge pclk);
        end
        checks++;
        if (cnt >= 1000) begin
            errors++; $display("FAIL busy_timeout: got %0d cycles, want < 1000", cnt);
        end
        repeat (3) @(negedge pclk);
`ifdef TILE_FETCH_MAP_CLEAR_EN
        exp_after = 4'd0;
`else
        exp_after = 4'd2;
`endif
        checks++;
        if (sel !== exp_after) begin
            errors++; $display("FAIL map_after_reset: got sel=%h, want %h", sel, exp_after);
        end
        hs = 1'b0; vs = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef TILE_FETCH_MAP_CLEAR_EN
        test_map_scan();
        test_clear_restart();
`endif
        test_map_fill();
        test_map_scan();
        test_tile_lookup();
        test_out_of_map();
        test_players();
        test_read_first();
        test_sync_delay();
        test_back_to_back();
        test_reset_mid_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
